// File: rtl/tramelblaze_intc.sv
// Prioritized edge-triggered interrupt controller for the TramelBlaze processor.
// Rising edges latch as pending bits; the lowest enabled index is served, with an EOI handshake.
module tramelblaze_intc #(
  parameter int          NUM_SRC = 8,
  parameter logic [15:0] BASE_ID = 16'h0040
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [15:0]        PORT_ID,
  input  logic [15:0]        OUT_PORT,
  input  logic               WRITE_STROBE,
  input  logic               READ_STROBE,
  input  logic               INTERRUPT_ACK,
  output logic               INTERRUPT,
  output logic [15:0]        RD_DATA,
  output logic               RD_HIT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_d_q, irq_d_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] rise, en, w1c, ack_clr;
  logic [3:0]         active_id_q, active_id_d;
  logic               in_service_q, in_service_d;
  logic [15:0]        offset;
  logic               wr_pending, wr_mask, wr_eoi;
  logic               unused_in;

  function automatic logic [3:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Reads are side-effect free, so READ_STROBE and unused data bits are only tied off.
  assign unused_in = READ_STROBE ^ (^OUT_PORT);

  assign offset     = PORT_ID - BASE_ID;
  assign RD_HIT     = (offset < 16'd4);
  assign wr_pending = WRITE_STROBE && RD_HIT && (offset[1:0] == 2'd0);
  assign wr_mask    = WRITE_STROBE && RD_HIT && (offset[1:0] == 2'd1);
  assign wr_eoi     = WRITE_STROBE && RD_HIT && (offset[1:0] == 2'd3);

  assign rise      = IRQ_IN & ~irq_d_q;
  assign en        = pending_q & mask_q;
  assign w1c       = wr_pending ? OUT_PORT[NUM_SRC-1:0] : '0;
  assign INTERRUPT = (state_q == ST_ASSERT);

  always_comb begin
    RD_DATA = '0;
    if (RD_HIT) begin
      case (offset[1:0])
        2'd0:    RD_DATA[NUM_SRC-1:0] = pending_q;
        2'd1:    RD_DATA[NUM_SRC-1:0] = mask_q;
        2'd2:    RD_DATA = {in_service_q, 11'd0, active_id_q};
        default: RD_DATA = '0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|en) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        // Withdraw the request if software masked or cleared everything meanwhile.
        if (!(|en)) begin
          state_d = ST_IDLE;
        end else if (INTERRUPT_ACK) begin
          state_d      = ST_SERVICE;
          active_id_d  = lowest_idx(en);
          in_service_d = 1'b1;
          ack_clr      = en & (~en + NUM_SRC'(1));
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new rise in the same cycle as a clear keeps the bit set.
  assign pending_d = (pending_q & ~w1c & ~ack_clr) | rise;
  assign mask_d    = wr_mask ? OUT_PORT[NUM_SRC-1:0] : mask_q;
  assign irq_d_d   = IRQ_IN;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      irq_d_q      <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      active_id_q  <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_d_q      <= irq_d_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
    end
  end

endmodule

// File: tb/tb_tramelblaze_intc.sv
// Self-checking bench for tramelblaze_intc: directed scenarios plus a randomized run
// compared against a register-level behavioural model.
module tb_tramelblaze_intc;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int          NS   = 8;
  localparam logic [15:0] FULL = 16'h00FF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  irq = '0;
  logic [15:0] PORT_ID = '0;
  logic [15:0] OUT_PORT = '0;
  logic        WRITE_STROBE = 1'b0;
  logic        READ_STROBE = 1'b0;
  logic        INTERRUPT_ACK = 1'b0;
  logic        intr8, hit8, intr4, hit4;
  logic [15:0] rd8, rd4;

  int errs = 0;
  int checks = 0;

  logic [15:0] m_pend, m_mask, m_prev;
  logic [3:0]  m_active;
  bit          m_req, m_serv;

  always #5 CLK = ~CLK;

  tramelblaze_intc #(.NUM_SRC(8), .BASE_ID(BASE)) dut8 (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(irq), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .WRITE_STROBE(WRITE_STROBE), .READ_STROBE(READ_STROBE), .INTERRUPT_ACK(INTERRUPT_ACK),
    .INTERRUPT(intr8), .RD_DATA(rd8), .RD_HIT(hit8)
  );

  tramelblaze_intc #(.NUM_SRC(4), .BASE_ID(BASE)) dut4 (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(irq[3:0]), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .WRITE_STROBE(WRITE_STROBE), .READ_STROBE(READ_STROBE), .INTERRUPT_ACK(INTERRUPT_ACK),
    .INTERRUPT(intr4), .RD_DATA(rd4), .RD_HIT(hit4)
  );

  // Reference model: registers as plain integers, one call per clock edge.
  task automatic model_step();
    logic [15:0] irq16, rise, en, w1c, clr, off;
    bit wr_ok, found;
    irq16 = {8'h00, irq};
    if (RESET) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_active = 0; m_req = 0; m_serv = 0;
      return;
    end
    off   = PORT_ID - BASE;
    wr_ok = WRITE_STROBE && (off < 16'd4);
    rise  = irq16 & ~m_prev;
    en    = m_pend & m_mask;
    w1c   = (wr_ok && off == 16'd0) ? (OUT_PORT & FULL) : 16'h0;
    clr   = 16'h0;
    if (m_req) begin
      if (en == 0) m_req = 0;
      else if (INTERRUPT_ACK) begin
        found = 0;
        for (int i = 0; i < NS; i++) begin
          if (!found && en[i]) begin
            m_active = 4'(i);
            clr = 16'h1 << i;
            found = 1;
          end
        end
        m_req = 0;
        m_serv = 1;
      end
    end else if (m_serv) begin
      if (wr_ok && off == 16'd3) m_serv = 0;
    end else if (en != 0) begin
      m_req = 1;
    end
    if (wr_ok && off == 16'd1) m_mask = OUT_PORT & FULL;
    m_pend = (m_pend & ~w1c & ~clr) | rise;
    m_prev = irq16;
  endtask

  function automatic logic [15:0] model_rd(input int off);
    case (off)
      0: return m_pend;
      1: return m_mask;
      2: return {m_serv, 11'd0, m_active};
      default: return 16'h0;
    endcase
  endfunction

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [15:0] data);
    PORT_ID = BASE + 16'(off);
    OUT_PORT = data;
    WRITE_STROBE = 1'b1;
    step();
    WRITE_STROBE = 1'b0;
    OUT_PORT = '0;
  endtask

  task automatic read_reg(input int off, output logic [15:0] d, output logic h,
                          output logic [15:0] d4);
    WRITE_STROBE = 1'b0;
    PORT_ID = BASE + 16'(off);
    #1;
    d = rd8;
    h = hit8;
    d4 = rd4;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d, d4;
    logic h;
    irq = '0;
    do_reset();
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL reset_intr actual=%b required=0", intr8); end
    for (int off = 0; off < 4; off++) begin
      read_reg(off, d, h, d4);
      checks++;
      if (d !== 16'h0 || h !== 1'b1) begin
        errs++; $display("FAIL reset_reg%0d actual=%h hit=%b required=0000 hit=1", off, d, h);
      end
    end
    // Line held high through reset registers as a rise afterwards.
    irq = 8'h40;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0040) begin errs++; $display("FAIL reset_held_line actual=%h required=0040", d); end
    irq = '0;
    step();
    do_reset();
  endtask

  task automatic test_basic();
    logic [15:0] d, d4;
    logic h;
    do_reset();
    wr_reg(1, 16'h00FF);
    irq[3] = 1'b1;
    step();
    irq[3] = 1'b0;
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0008) begin errs++; $display("FAIL basic_pending actual=%h required=0008", d); end
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL basic_intr_early actual=%b required=0", intr8); end
    step();
    checks++;
    if (intr8 !== 1'b1) begin errs++; $display("FAIL basic_intr actual=%b required=1", intr8); end
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h0000) begin errs++; $display("FAIL basic_status actual=%h required=0000", d); end
  endtask

  task automatic test_ack_eoi();
    logic [15:0] d, d4;
    logic h;
    irq[5] = 1'b1;
    step();
    irq[5] = 1'b0;
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0028) begin errs++; $display("FAIL ack_pre_pending actual=%h required=0028", d); end
    INTERRUPT_ACK = 1'b1;
    step();
    INTERRUPT_ACK = 1'b0;
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL ack_intr actual=%b required=0", intr8); end
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h8003) begin errs++; $display("FAIL ack_status actual=%h required=8003", d); end
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0020) begin errs++; $display("FAIL ack_pending actual=%h required=0020", d); end
    wr_reg(3, 16'hABCD);
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h0003) begin errs++; $display("FAIL eoi_status actual=%h required=0003", d); end
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL eoi_intr_idle actual=%b required=0", intr8); end
    step();
    checks++;
    if (intr8 !== 1'b1) begin errs++; $display("FAIL eoi_reassert actual=%b required=1", intr8); end
    INTERRUPT_ACK = 1'b1;
    step();
    INTERRUPT_ACK = 1'b0;
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h8005) begin errs++; $display("FAIL ack2_status actual=%h required=8005", d); end
    wr_reg(3, 16'h0);
    step();
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL drained_intr actual=%b required=0", intr8); end
  endtask

  task automatic test_mask_gate();
    logic [15:0] d, d4;
    logic h;
    do_reset();
    irq[0] = 1'b1;
    step();
    irq[0] = 1'b0;
    step();
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0001) begin errs++; $display("FAIL masked_pending actual=%h required=0001", d); end
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL masked_intr actual=%b required=0", intr8); end
    wr_reg(1, 16'h0001);
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL unmask_early actual=%b required=0", intr8); end
    step();
    checks++;
    if (intr8 !== 1'b1) begin errs++; $display("FAIL unmask_intr actual=%b required=1", intr8); end
    wr_reg(0, 16'h0001);
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0000) begin errs++; $display("FAIL w1c_pending actual=%h required=0000", d); end
    step();
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL w1c_withdraw actual=%b required=0", intr8); end
  endtask

  task automatic test_set_wins();
    logic [15:0] d, d4;
    logic h;
    do_reset();
    wr_reg(1, 16'h0004);
    irq[2] = 1'b1;
    step();
    irq[2] = 1'b0;
    step();
    irq[2] = 1'b1;
    wr_reg(0, 16'h0004);
    irq[2] = 1'b0;
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0004) begin errs++; $display("FAIL set_wins_pending actual=%h required=0004", d); end
    checks++;
    if (intr8 !== 1'b1) begin errs++; $display("FAIL set_wins_intr actual=%b required=1", intr8); end
    INTERRUPT_ACK = 1'b1;
    step();
    INTERRUPT_ACK = 1'b0;
    wr_reg(3, 16'h0);
    INTERRUPT_ACK = 1'b1;
    step();
    INTERRUPT_ACK = 1'b0;
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h0002) begin errs++; $display("FAIL idle_ack_status actual=%h required=0002", d); end
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL idle_ack_intr actual=%b required=0", intr8); end
  endtask

  task automatic test_reset_in_service();
    logic [15:0] d, d4;
    logic h;
    do_reset();
    wr_reg(1, 16'h00FF);
    irq = 8'h12;
    step();
    irq = 8'h00;
    step();
    INTERRUPT_ACK = 1'b1;
    step();
    INTERRUPT_ACK = 1'b0;
    read_reg(0, d, h, d4);
    checks++;
    if (d !== 16'h0010) begin errs++; $display("FAIL svc_pending actual=%h required=0010", d); end
    do_reset();
    checks++;
    if (intr8 !== 1'b0) begin errs++; $display("FAIL rst_svc_intr actual=%b required=0", intr8); end
    for (int off = 0; off < 3; off++) begin
      read_reg(off, d, h, d4);
      checks++;
      if (d !== 16'h0) begin errs++; $display("FAIL rst_svc_reg%0d actual=%h required=0000", off, d); end
    end
    wr_reg(3, 16'h0);
    read_reg(2, d, h, d4);
    checks++;
    if (d !== 16'h0 || intr8 !== 1'b0) begin
      errs++; $display("FAIL eoi_after_rst actual=%h intr=%b required=0000 intr=0", d, intr8);
    end
  endtask

  task automatic test_decode();
    logic [15:0] d, d4;
    logic h;
    read_reg(4, d, h, d4);
    checks++;
    if (h !== 1'b0 || d !== 16'h0) begin
      errs++; $display("FAIL decode_base4 actual=%h hit=%b required=0000 hit=0", d, h);
    end
    read_reg(-1, d, h, d4);
    checks++;
    if (h !== 1'b0 || d !== 16'h0) begin
      errs++; $display("FAIL decode_below actual=%h hit=%b required=0000 hit=0", d, h);
    end
    read_reg(3, d, h, d4);
    checks++;
    if (h !== 1'b1 || d !== 16'h0) begin
      errs++; $display("FAIL decode_eoi_read actual=%h hit=%b required=0000 hit=1", d, h);
    end
    wr_reg(1, 16'hFFFF);
    read_reg(1, d, h, d4);
    checks++;
    if (d4 !== 16'h000F) begin errs++; $display("FAIL mask_width4 actual=%h required=000F", d4); end
    checks++;
    if (d !== 16'h00FF) begin errs++; $display("FAIL mask_width8 actual=%h required=00FF", d); end
  endtask

  task automatic test_random();
    logic [15:0] d, d4, e;
    logic h;
    do_reset();
    wr_reg(1, 16'h00FF);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ (8'h1 << $urandom_range(0, 7));
      WRITE_STROBE = ($urandom_range(0, 4) == 0);
      PORT_ID = BASE + 16'($urandom_range(0, 4));
      OUT_PORT = 16'($urandom);
      INTERRUPT_ACK = ($urandom_range(0, 2) == 0);
      RESET = ($urandom_range(0, 99) == 0);
      step();
      WRITE_STROBE = 1'b0;
      INTERRUPT_ACK = 1'b0;
      RESET = 1'b0;
      checks++;
      if (intr8 !== m_req) begin
        errs++; $display("FAIL rand_intr cycle=%0d actual=%b required=%b", n, intr8, m_req);
      end
      for (int off = 0; off < 4; off++) begin
        read_reg(off, d, h, d4);
        e = model_rd(off);
        checks++;
        if (d !== e || h !== 1'b1) begin
          errs++; $display("FAIL rand_reg%0d cycle=%0d actual=%h required=%h", off, n, d, e);
        end
      end
    end
  endtask

  initial begin
    m_pend = 0; m_mask = 0; m_prev = 0; m_active = 0; m_req = 0; m_serv = 0;
    #2;
    test_reset();
    test_basic();
    test_ack_eoi();
    test_mask_gate();
    test_set_wins();
    test_reset_in_service();
    test_decode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tramelblaze_intc.md
Name: tramelblaze_intc

Overview:
Prioritized interrupt controller for the TramelBlaze processor subsystem. It collects up to NUM_SRC peripheral interrupt lines, latches rising edges as pending bits, and drives the processor's single INTERRUPT input. It sequences the INTERRUPT / INTERRUPT_ACK handshake and the end-of-interrupt (EOI) handshake. Software reads and configures it through the processor's PORT_ID / IN_PORT / OUT_PORT I/O bus.

Parameters:
NUM_SRC, 8, number of interrupt sources; legal range 1..15.
BASE_ID, 16'h0040, port ID of the first of 4 consecutive controller registers.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RESET  in  1  synchronous, active-high reset.
IRQ_IN  in  NUM_SRC  peripheral interrupt lines; rising edge triggers; bit 0 has highest priority.
PORT_ID  in  16  processor port address.
OUT_PORT  in  16  processor write data.
WRITE_STROBE  in  1  processor write qualifier, one cycle.
READ_STROBE  in  1  processor read qualifier; informational only; reads have no side effects.
INTERRUPT_ACK  in  1  processor acknowledge, one cycle.
INTERRUPT  out  1  interrupt request to the processor.
RD_DATA  out  16  read data for the top-level IN_PORT mux.
RD_HIT  out  1  high when PORT_ID is in BASE_ID..BASE_ID+3; the top level uses it to select RD_DATA.

Behaviour:
Register map (offset from BASE_ID):
- +0 PENDING: read returns pending bits. Write is write-1-to-clear, using OUT_PORT[NUM_SRC-1:0].
- +1 MASK: read/write. A 1 bit enables that source.
- +2 STATUS: read-only. [3:0] = ACTIVE_ID; [15] = in-service flag; other bits 0.
- +3 EOI: write-only. Data is ignored. Reads return 0.
- Bits at and above NUM_SRC read 0 and are ignored on write.

Read path:
- RD_DATA and RD_HIT are combinational from PORT_ID.
- RD_DATA = 0 when RD_HIT = 0.

Edge detect and pending:
- irq_d register holds IRQ_IN delayed by one cycle.
- Rise on bit i = IRQ_IN[i] & ~irq_d[i], evaluated at edge k. PENDING[i] = 1 after edge k.
- Pending bits latch regardless of MASK.
- Same-cycle set and clear on one bit (W1C or ack auto-clear): set wins.

Enabled set: EN = PENDING & MASK.

State machine (2-bit state register; INTERRUPT = (state == ASSERT), glitch-free):
- IDLE -> ASSERT when EN != 0.
- ASSERT -> SERVICE on INTERRUPT_ACK with EN != 0:
  - ACTIVE_ID <= index of the lowest set bit of EN.
  - That PENDING bit is cleared (unless a new rise on it occurs in the same cycle).
  - The in-service flag is set.
- ASSERT -> IDLE when EN == 0, whether or not ACK is present. Covers software masking or clearing while the request is outstanding.
- SERVICE -> IDLE on a write to EOI. The in-service flag is cleared; ACTIVE_ID holds its value.
- INTERRUPT_ACK outside ASSERT: ignored.
- EOI write outside SERVICE: ignored.

Nesting and latency:
- No nesting: new events only accumulate in PENDING during SERVICE.
- After EOI, the controller returns to IDLE. If EN != 0, INTERRUPT re-asserts one edge later.
- Latency: IRQ_IN rise sampled at edge k; INTERRUPT = 1 after edge k+1 (source enabled, state IDLE).

RESET (synchronous, any time, including mid-SERVICE):
- state = IDLE, INTERRUPT = 0, PENDING = 0, MASK = 0, ACTIVE_ID = 0, in-service = 0, irq_d = 0.
- A line held high through reset counts as a rise on the first cycle after reset.

Test Plan:
- Reset, then MASK = 16'h00FF; pulse IRQ_IN[3] -> PENDING = 16'h0008 after edge k; INTERRUPT = 1 after edge k+1; STATUS reads 0.
- In ASSERT with PENDING = 16'h0028, pulse INTERRUPT_ACK -> INTERRUPT = 0, STATUS = 16'h8003, PENDING = 16'h0020. Write EOI -> STATUS = 16'h0003; INTERRUPT = 1 one edge after the IDLE transition (source 5 still pending).
- MASK = 16'h0000; pulse IRQ_IN[0] -> PENDING = 16'h0001, INTERRUPT stays 0. Write MASK = 16'h0001 -> INTERRUPT = 1 two edges later. Write PENDING W1C 16'h0001 -> INTERRUPT = 0 and state back to IDLE.
- In ASSERT, IRQ_IN[2] rises in the same cycle as a W1C of bit 2 -> PENDING[2] stays 1. INTERRUPT_ACK while IDLE -> no state change, STATUS unchanged.
- RESET asserted during SERVICE with PENDING = 16'h0010 -> after one edge: INTERRUPT = 0, PENDING = 0, MASK = 0, STATUS = 0. A later EOI write is ignored.
- PORT_ID = BASE_ID+4 -> RD_HIT = 0, RD_DATA = 0. NUM_SRC = 4: write MASK = 16'hFFFF -> MASK reads 16'h000F.
